// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Latency: request granted in cycle N gives a registered response in cycle N+2; one operation in flight at a time.
// Backpressure: the response is held in HOLD until rsp_ready_i; no grant is given until it is taken.
module alu_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [DWIDTH-1:0] req0_src1_i,
  input  logic [DWIDTH-1:0] req0_src2_i,
  input  logic [3:0]        req0_ctrl_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DWIDTH-1:0] req1_src1_i,
  input  logic [DWIDTH-1:0] req1_src2_i,
  input  logic [3:0]        req1_ctrl_i,
  output logic              req1_ready_o,
  output logic [DWIDTH-1:0] alu_src1_o,
  output logic [DWIDTH-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DWIDTH-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DWIDTH-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  input  logic              rsp_ready_i
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state;
  logic              prio;
  logic [DWIDTH-1:0] op_src1;
  logic [DWIDTH-1:0] op_src2;
  logic [3:0]        op_ctrl;
  logic              op_id;
  logic              gnt0;
  logic              gnt1;
  logic              can_grant;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer holder.
  // Grants are masked while reset is held so nothing is accepted before release.
  always_comb begin
    can_grant = (state == IDLE) && rst_i;
    gnt1      = req1_valid_i && (!req0_valid_i || prio);
    gnt0      = req0_valid_i && !gnt1;
  end

  assign req0_ready_o = can_grant && gnt0;
  assign req1_ready_o = can_grant && gnt1;

  // The ALU always sees the captured operands; codes are passed through untouched.
  assign alu_src1_o = op_src1;
  assign alu_src2_o = op_src2;
  assign alu_ctrl_o = op_ctrl;

  // Control FSM: capture on grant, latch the ALU result, hold until consumed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      prio         <= 1'b0;
      op_src1      <= '0;
      op_src2      <= '0;
      op_ctrl      <= 4'b0010;
      op_id        <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_src1 <= gnt1 ? req1_src1_i : req0_src1_i;
            op_src2 <= gnt1 ? req1_src2_i : req0_src2_i;
            op_ctrl <= gnt1 ? req1_ctrl_i : req0_ctrl_i;
            op_id   <= gnt1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_o <= alu_result_i;
          rsp_zero_o   <= alu_zero_i;
          rsp_id_o     <= op_id;
          rsp_valid_o  <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            prio        <= ~prio;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small behavioural ALU on the shared port.
// Latency: expectations are pushed at grant and compared every HOLD cycle.
// Backpressure: rsp_ready_i is driven low in chosen windows and at random.
module tb_alu_arbiter;

  localparam int DW = 32;

  typedef struct {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
  } exp_t;

  typedef enum int {M_IDLE, M_EXEC, M_HOLD} mstate_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req0_valid_i, req1_valid_i;
  logic [DW-1:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
  logic [3:0]    req0_ctrl_i, req1_ctrl_i;
  logic          req0_ready_o, req1_ready_o;
  logic [DW-1:0] alu_src1_o, alu_src2_o, alu_result_i;
  logic [3:0]    alu_ctrl_o;
  logic          alu_zero_i;
  logic          rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_ready_i;
  logic [DW-1:0] rsp_result_o;

  int      err_cnt = 0;
  int      chk_cnt = 0;
  int      cyc = 0;
  int      grant_cyc = 0;
  bit      first_hold = 1'b0;
  mstate_t m_state = M_IDLE;
  bit      m_prio = 1'b0;
  exp_t    sb[$];
  int      grant_log[$];
  exp_t    rsp_log[$];

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [3:0] c);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result_i = alu_fn(alu_src1_o, alu_src2_o, alu_ctrl_o);
  assign alu_zero_i   = (alu_result_i == '0);

  alu_arbiter #(.DWIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i),
    .req0_ctrl_i(req0_ctrl_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i),
    .req1_ctrl_i(req1_ctrl_i), .req1_ready_o(req1_ready_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o),
    .rsp_zero_o(rsp_zero_o), .rsp_ready_i(rsp_ready_i)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk_i) begin
    bit   g0, g1;
    exp_t e;
    cyc++;
    if (!rst_i) begin
      check("rst_ready0", req0_ready_o, 0);
      check("rst_ready1", req1_ready_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_id", rsp_id_o, 0);
      check("rst_rsp_result", rsp_result_o, 0);
      check("rst_rsp_zero", rsp_zero_o, 0);
      check("rst_alu_src1", alu_src1_o, 0);
      check("rst_alu_src2", alu_src2_o, 0);
      check("rst_alu_ctrl", alu_ctrl_o, 4'b0010);
      m_state = M_IDLE;
      m_prio  = 1'b0;
      sb.delete();
    end else begin
      case (m_state)
        M_IDLE: begin
          g1 = req1_valid_i && (!req0_valid_i || m_prio);
          g0 = req0_valid_i && !g1;
          check("idle_ready0", req0_ready_o, g0);
          check("idle_ready1", req1_ready_o, g1);
          check("idle_rsp_valid", rsp_valid_o, 0);
          if (g0 || g1) begin
            e.id   = g1;
            e.res  = g1 ? alu_fn(req1_src1_i, req1_src2_i, req1_ctrl_i)
                        : alu_fn(req0_src1_i, req0_src2_i, req0_ctrl_i);
            e.zero = (e.res == '0);
            sb.push_back(e);
            grant_log.push_back(g1 ? 1 : 0);
            grant_cyc  = cyc;
            first_hold = 1'b1;
            m_state    = M_EXEC;
          end
        end
        M_EXEC: begin
          check("exec_ready0", req0_ready_o, 0);
          check("exec_ready1", req1_ready_o, 0);
          check("exec_rsp_valid", rsp_valid_o, 0);
          m_state = M_HOLD;
        end
        default: begin
          check("hold_ready0", req0_ready_o, 0);
          check("hold_ready1", req1_ready_o, 0);
          check("hold_rsp_valid", rsp_valid_o, 1);
          if (first_hold) begin
            check("latency", cyc - grant_cyc, 2);
            first_hold = 1'b0;
          end
          if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
          end else begin
            check("rsp_id", rsp_id_o, sb[0].id);
            check("rsp_result", rsp_result_o, sb[0].res);
            check("rsp_zero", rsp_zero_o, sb[0].zero);
          end
          if (rsp_ready_i) begin
            e.id = rsp_id_o; e.res = rsp_result_o; e.zero = rsp_zero_o;
            rsp_log.push_back(e);
            if (sb.size() != 0) void'(sb.pop_front());
            m_prio  = !m_prio;
            m_state = M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (grant_log.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    if (grant_log.size() < n) check("grant_timeout", grant_log.size(), n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_state != M_IDLE || sb.size() != 0) && k < 200) begin
      tick(1);
      k++;
    end
    if (m_state != M_IDLE || sb.size() != 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int base, r;
    rst_i = 1'b0; rsp_ready_i = 1'b1;
    req0_valid_i = 0; req0_src1_i = 0; req0_src2_i = 0; req0_ctrl_i = 0;
    req1_valid_i = 0; req1_src1_i = 0; req1_src2_i = 0; req1_ctrl_i = 0;
    // Requests are already pending during reset; no grant may appear before release.
    req0_valid_i = 1; req0_src1_i = 5; req0_src2_i = 7; req0_ctrl_i = 4'b0010;
    tick(3);
    check("no_grant_in_reset", grant_log.size(), 0);
    rst_i = 1'b1;

    // Single request: 5+7.
    wait_grants(1);
    req0_valid_i = 0;
    drain();
    check("single_result", rsp_log[0].res, 12);
    check("single_zero", rsp_log[0].zero, 0);
    check("single_id", rsp_log[0].id, 0);

    // Simultaneous after reset: req0 3+4 first, then req1 9-9.
    rst_i = 1'b0; tick(2); rst_i = 1'b1;
    base = grant_log.size(); r = rsp_log.size();
    req0_valid_i = 1; req0_src1_i = 3; req0_src2_i = 4; req0_ctrl_i = 4'b0010;
    req1_valid_i = 1; req1_src1_i = 9; req1_src2_i = 9; req1_ctrl_i = 4'b0110;
    wait_grants(base + 1); req0_valid_i = 0;
    wait_grants(base + 2); req1_valid_i = 0;
    drain();
    check("sim_first_result", rsp_log[r].res, 7);
    check("sim_first_id", rsp_log[r].id, 0);
    check("sim_second_result", rsp_log[r+1].res, 0);
    check("sim_second_zero", rsp_log[r+1].zero, 1);
    check("sim_second_id", rsp_log[r+1].id, 1);

    // Fairness: both held valid for six operations.
    base = grant_log.size();
    req0_valid_i = 1; req1_valid_i = 1;
    wait_grants(base + 6);
    req0_valid_i = 0; req1_valid_i = 0;
    drain();
    for (int i = 0; i < 6; i++) check($sformatf("fair_order_%0d", i), grant_log[base+i], i % 2);

    // Back-pressure: response held for several cycles.
    rsp_ready_i = 0; r = rsp_log.size();
    req1_valid_i = 1; req1_src1_i = 32'hF0F0; req1_src2_i = 32'h0F0F; req1_ctrl_i = 4'b0001;
    wait_grants(grant_log.size() + 1); req1_valid_i = 0;
    req0_valid_i = 1; req0_src1_i = 1; req0_src2_i = 1; req0_ctrl_i = 4'b0000;
    tick(6);
    check("bp_still_valid", rsp_valid_o, 1);
    rsp_ready_i = 1;
    wait_grants(grant_log.size() + 1); req0_valid_i = 0;
    drain();
    check("bp_result", rsp_log[r].res, 32'hFFFF);
    check("bp_next_result", rsp_log[r+1].res, 1);

    // A pulse from the other requester while busy causes no grant.
    base = grant_log.size();
    req0_valid_i = 1; req0_src1_i = 10; req0_src2_i = 3; req0_ctrl_i = 4'b0110;
    wait_grants(base + 1); req0_valid_i = 0;
    req1_valid_i = 1; rsp_ready_i = 0;
    tick(1);
    req1_valid_i = 0;
    tick(1);
    rsp_ready_i = 1;
    drain(); tick(3);
    check("pulse_no_grant", grant_log.size(), base + 1);

    // Reset during EXEC discards the operation.
    req0_valid_i = 1; req0_src1_i = 2; req0_src2_i = 2; req0_ctrl_i = 4'b0010;
    r = rsp_log.size();
    wait_grants(grant_log.size() + 1); req0_valid_i = 0;
    rst_i = 1'b0;
    tick(2);
    rst_i = 1'b1;
    tick(5);
    check("rst_midop_no_rsp", rsp_log.size(), r);
    check("rst_midop_valid", rsp_valid_o, 0);

    // Random traffic with random back-pressure.
    base = grant_log.size();
    req0_valid_i = 1; req1_valid_i = 1;
    while (grant_log.size() < base + 12 && cyc < 5000) begin
      r = grant_log.size();
      tick(1);
      rsp_ready_i = $urandom_range(0, 1);
      if (grant_log.size() != r) begin
        if (grant_log[$] == 0) begin
          req0_src1_i = $urandom; req0_src2_i = $urandom_range(0, 3) == 0 ? req0_src1_i : $urandom;
          req0_ctrl_i = 4'($urandom_range(0, 7));
        end else begin
          req1_src1_i = $urandom; req1_src2_i = $urandom_range(0, 3) == 0 ? req1_src1_i : $urandom;
          req1_ctrl_i = 4'($urandom_range(0, 7));
        end
      end
    end
    if (grant_log.size() < base + 12) check("rand_timeout", grant_log.size(), base + 12);
    req0_valid_i = 0; req1_valid_i = 0; rsp_ready_i = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
